// File: rtl/ps2_uart_tx.sv
// ps2_uart_tx: buffers ASCII characters from the keyboard front end in a
// small circular FIFO and serialises them as 8N1 UART frames toward the
// host. The host's clear-to-send gates the start of each frame.
module ps2_uart_tx #(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          character_valid,
    output logic                          character_ready,
    input  logic [7:0]                    character_byte,
    input  logic                          cts,
    output logic                          uart_tx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int DIVISOR = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;
    localparam int BW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    localparam logic [BW-1:0] BAUD_LAST  = BW'(DIVISOR - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    // Refuse to build with a baud divisor too small for a bit period or a
    // FIFO depth the wrapping pointers cannot represent.
    generate
        if (DIVISOR < 2) begin : gDivisorCheck
            $error("ps2_uart_tx: baud divisor must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : gDepthCheck
            $error("ps2_uart_tx: FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_t;

    txState_t          state_q, state_d;
    logic [BW-1:0]     baudCnt_q, baudCnt_d;
    logic [2:0]        bitIdx_q, bitIdx_d;
    logic [7:0]        shift_q, shift_d;
    logic              txLine_q, txLine_d;

    logic [7:0]        fifoMem_q [FIFO_DEPTH];
    logic [PW-1:0]     wrPtr_q, rdPtr_q;
    logic [CW-1:0]     count_q;

    logic              push;
    logic              pop;

    // Ready comes from the occupancy register alone, so a pop in the same
    // cycle never opens the door; it is also held low while reset is applied.
    assign character_ready = !reset && (count_q != FULL_COUNT);
    assign push            = character_valid && character_ready;
    assign fifo_count      = count_q;
    assign uart_tx         = txLine_q;
    assign busy            = (state_q != IDLE);

    // Character storage: written only on an accepted handshake.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= character_byte;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Transmitter state register; the line is registered so it never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            txLine_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            txLine_q  <= txLine_d;
        end
    end

    // Frame sequencing: IDLE spends one decision cycle, then start, eight
    // data bits LSB first and a stop bit, each DIVISOR clocks long.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        txLine_d  = 1'b1;

        case (state_q)
            IDLE: begin
                baudCnt_d = '0;
                bitIdx_d  = '0;
                if ((count_q != '0) && cts) begin
                    pop     = 1'b1;
                    shift_d = fifoMem_q[rdPtr_q];
                    state_d = START;
                end
            end
            START: begin
                if (baudCnt_q == BAUD_LAST) begin
                    baudCnt_d = '0;
                    bitIdx_d  = '0;
                    state_d   = DATA;
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
            DATA: begin
                if (baudCnt_q == BAUD_LAST) begin
                    baudCnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
            STOP: begin
                if (baudCnt_q == BAUD_LAST) begin
                    baudCnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   txLine_d = 1'b0;
            DATA:    txLine_d = shift_d[bitIdx_d];
            default: txLine_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_ps2_uart_tx.sv
// Testbench for ps2_uart_tx: a feeder drives the character handshake and
// queues every accepted byte; a line monitor decodes UART frames and checks
// them against that queue. Directed sequences cover latency, flow control,
// back-to-back framing and reset in the middle of a frame.
module tb_ps2_uart_tx;

    localparam int CLK_HZ = 16;
    localparam int BAUD   = 1;
    localparam int DEPTH  = 4;
    localparam int DIV    = 16;

    typedef struct {
        logic expTx;
        logic expBusy;
        int   nClk;
    } seg_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       character_valid = 1'b0;
    logic       character_ready;
    logic [7:0] character_byte = 8'h00;
    logic       cts = 1'b0;
    logic       uart_tx;
    logic [2:0] fifo_count;
    logic       busy;

    int         cyc = 0;
    int         nVec = 0;
    int         nFail = 0;
    logic [7:0] feedQ[$];
    logic [7:0] expQ[$];
    int         startCycQ[$];
    int         lastAcceptCyc = 0;
    int         maxCount = 0;
    bit         monEnable = 1'b0;
    bit         monActive = 1'b0;

    ps2_uart_tx #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .character_valid(character_valid),
        .character_ready(character_ready),
        .character_byte(character_byte),
        .cts(cts),
        .uart_tx(uart_tx),
        .fifo_count(fifo_count),
        .busy(busy)
    );

    // Free-running clock and an edge counter used for latency measurements.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVec++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name, input int actual, input int limit);
        nVec++;
        nFail++;
        $display("[TB] FAIL %s: reached %0d, limit %0d", name, actual, limit);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        feedQ.push_back(b);
    endtask

    task automatic waitBusyRise(input string name, input int maxCyc, output logic [2:0] prevCount);
        int n = 0;
        prevCount = fifo_count;
        while (busy !== 1'b1 && n < maxCyc) begin
            prevCount = fifo_count;
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b1) failNow(name, n, maxCyc);
    endtask

    task automatic waitBusyFall(input string name, input int maxCyc);
        int n = 0;
        while (busy !== 1'b0 && n < maxCyc) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b0) failNow(name, n, maxCyc);
    endtask

    task automatic waitDrain(input string name, input int maxCyc);
        int n = 0;
        while ((feedQ.size() != 0 || expQ.size() != 0 || busy !== 1'b0 || monActive ||
                fifo_count !== 3'd0) && n < maxCyc) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= maxCyc) failNow(name, n, maxCyc);
    endtask

    // Feeder: offers the head of feedQ; an offer seen with ready high before
    // an edge is an acceptance, so the byte moves to the expected queue.
    initial begin : feeder
        bit offered;
        forever begin
            @(negedge clk);
            offered = character_valid && character_ready && !reset;
            if (!reset && int'(fifo_count) > maxCount) maxCount = int'(fifo_count);
            @(posedge clk); #1;
            if (offered) begin
                expQ.push_back(feedQ.pop_front());
                lastAcceptCyc = cyc;
            end
            if (feedQ.size() > 0) begin
                character_valid = 1'b1;
                character_byte  = feedQ[0];
            end else begin
                character_valid = 1'b0;
            end
        end
    end

    // Line monitor: decodes each frame at bit centres and scores its byte.
    initial begin : monitor
        logic [7:0] got;
        logic [7:0] expd;
        forever begin
            @(posedge clk); #1;
            if (monEnable && !reset && uart_tx === 1'b0) begin
                monActive = 1'b1;
                startCycQ.push_back(cyc);
                repeat (DIV / 2) @(posedge clk);
                #1;
                checkOutput("start_bit", {31'd0, uart_tx}, 32'd0);
                for (int b = 0; b < 8; b++) begin
                    repeat (DIV) @(posedge clk);
                    #1;
                    got[b] = uart_tx;
                end
                repeat (DIV) @(posedge clk);
                #1;
                checkOutput("stop_bit", {31'd0, uart_tx}, 32'd1);
                if (expQ.size() == 0) begin
                    failNow("frame_without_accepted_char", int'(got), -1);
                end else begin
                    expd = expQ.pop_front();
                    checkOutput("frame_byte", {24'd0, got}, {24'd0, expd});
                end
                monActive = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : main
        seg_t       segs[11];
        logic [2:0] prevCount;
        int         bad;
        int         riseCyc;
        int         fallCyc;
        int         busyCyc;
        int         txLowCyc;

        // Expected line for 'A' (0x41): start, bits LSB first, stop, idle.
        segs[0]  = '{1'b0, 1'b1, DIV};
        segs[1]  = '{1'b1, 1'b1, DIV};
        segs[2]  = '{1'b0, 1'b1, DIV};
        segs[3]  = '{1'b0, 1'b1, DIV};
        segs[4]  = '{1'b0, 1'b1, DIV};
        segs[5]  = '{1'b0, 1'b1, DIV};
        segs[6]  = '{1'b0, 1'b1, DIV};
        segs[7]  = '{1'b1, 1'b1, DIV};
        segs[8]  = '{1'b0, 1'b1, DIV};
        segs[9]  = '{1'b1, 1'b1, DIV};
        segs[10] = '{1'b1, 1'b0, 4};

        // Reset state.
        reset = 1'b1;
        cts   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_fifo_count", {29'd0, fifo_count}, 32'd0);
        checkOutput("reset_ready", {31'd0, character_ready}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("ready_after_reset", {31'd0, character_ready}, 32'd1);
        monEnable = 1'b1;
        cts = 1'b1;

        // Single character: latency, exact frame shape and busy duration.
        applyStimulus(8'h41);
        waitBusyRise("t1_busy_rise", 50, prevCount);
        checkOutput("t1_count_before_pop", {29'd0, prevCount}, 32'd1);
        checkOutput("t1_count_after_pop", {29'd0, fifo_count}, 32'd0);
        checkOutput("t1_accept_to_start", cyc - lastAcceptCyc, 32'd1);
        for (int s = 0; s < 11; s++) begin
            bad = 0;
            for (int k = 0; k < segs[s].nClk; k++) begin
                if (uart_tx !== segs[s].expTx || busy !== segs[s].expBusy) bad++;
                @(posedge clk); #1;
            end
            checkOutput($sformatf("t1_segment%0d_bad_cycles", s), bad, 32'd0);
        end
        waitDrain("t1_drain", 100);

        // Flow control: cts low fills the FIFO and back-pressures upstream.
        cts = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(8'(8'h31 + i));
        repeat (12) @(posedge clk);
        #1;
        checkOutput("t2_full_count", {29'd0, fifo_count}, 32'd4);
        checkOutput("t2_full_ready", {31'd0, character_ready}, 32'd0);
        checkOutput("t2_accepted", expQ.size(), 32'd4);
        checkOutput("t2_held_upstream", feedQ.size(), 32'd1);
        checkOutput("t2_idle_line", {30'd0, uart_tx, busy}, 32'd2);
        startCycQ.delete();
        maxCount = 0;
        cts = 1'b1;
        waitDrain("t2_drain", 1100);
        checkOutput("t2_frames", startCycQ.size(), 32'd5);
        if (startCycQ.size() > 0)
            checkOutput("t2_accept_after_first_pop", lastAcceptCyc - startCycQ[0], 32'd1);
        checkOutput("t2_max_count", maxCount, 32'd4);

        // Back-to-back frames with pointer wrap.
        startCycQ.delete();
        for (int i = 0; i < 6; i++) applyStimulus(8'(8'h61 + i));
        waitDrain("t4_drain", 1300);
        checkOutput("t4_frames", startCycQ.size(), 32'd6);
        for (int i = 1; i < startCycQ.size(); i++)
            checkOutput($sformatf("t4_gap%0d", i), startCycQ[i] - startCycQ[i-1], 32'd161);

        // cts drops mid-frame: frame completes, no new frame starts.
        startCycQ.delete();
        applyStimulus(8'h55);
        applyStimulus(8'h56);
        waitBusyRise("t5_busy_rise", 50, prevCount);
        riseCyc = cyc;
        repeat (39) @(posedge clk);
        #1;
        cts = 1'b0;
        waitBusyFall("t5_busy_fall", 200);
        fallCyc = cyc;
        checkOutput("t5_frame_len", fallCyc - riseCyc, 32'd160);
        busyCyc = 0;
        for (int k = 0; k < 300; k++) begin
            if (busy !== 1'b0) busyCyc++;
            @(posedge clk); #1;
        end
        checkOutput("t5_busy_while_cts_low", busyCyc, 32'd0);
        checkOutput("t5_frames_sent", startCycQ.size(), 32'd1);
        checkOutput("t5_count_held", {29'd0, fifo_count}, 32'd1);
        cts = 1'b1;
        waitDrain("t5_drain", 400);
        checkOutput("t5_frames_after_cts", startCycQ.size(), 32'd2);

        // Reset during a frame with characters still queued.
        monEnable = 1'b0;
        cts = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'h71 + i));
        repeat (12) @(posedge clk);
        #1;
        cts = 1'b1;
        waitBusyRise("t6_busy_rise", 50, prevCount);
        repeat (69) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("t6_reset_uart_tx", {31'd0, uart_tx}, 32'd1);
        checkOutput("t6_reset_count", {29'd0, fifo_count}, 32'd0);
        checkOutput("t6_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_reset_ready", {31'd0, character_ready}, 32'd0);
        reset = 1'b0;
        expQ.delete();
        busyCyc = 0;
        txLowCyc = 0;
        for (int k = 0; k < 250; k++) begin
            if (busy !== 1'b0) busyCyc++;
            if (uart_tx !== 1'b1) txLowCyc++;
            @(posedge clk); #1;
        end
        checkOutput("t6_no_frame_busy", busyCyc, 32'd0);
        checkOutput("t6_no_frame_line", txLowCyc, 32'd0);
        monEnable = 1'b1;
        startCycQ.delete();
        applyStimulus(8'h7A);
        waitDrain("t6_drain", 300);
        checkOutput("t6_frames_after_push", startCycQ.size(), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
